// File: rtl/operand_entry_pkg.sv
// Shared definitions for the 5-bit adding machine.
//   OPERAND_WIDTH  : operand width; the downstream sum is one bit wider
//   DEBOUNCE_50MHZ : 10 ms of stable key level at a 50 MHz clock
//   state_e        : capture FSM encoding, also exported on STATE_OUT
package operand_entry_pkg;

    localparam int OPERAND_WIDTH  = 5;
    localparam int DEBOUNCE_50MHZ = 500000;

    typedef enum logic [1:0] {
        WAIT_A  = 2'b00,
        WAIT_B  = 2'b01,
        DONE    = 2'b10,
        ILLEGAL = 2'b11
    } state_e;

endpackage

// File: rtl/operand_entry_key_debounce.sv
// Debouncer for one raw active-low pushbutton.
// The key is synchronised by two flops. A counter then runs while the
// synchronised key differs from the accepted level, and the level flips after
// DEBOUNCE_CYCLES consecutive mismatches. PRESS is a one-cycle pulse on the
// accepted 1->0 edge. Releasing the key produces no pulse.
//   CLOCK_50 : system clock
//   RESET_N  : asynchronous active-low reset
//   KEY_N    : raw key, active-low, bouncy, asynchronous
//   PRESS    : one-cycle press pulse
module key_debounce
    import operand_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_50MHZ
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic KEY_N,
    output logic PRESS
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             vld1_q, vld2_q;
    logic             level_q, level_d;
    logic             level_old_q;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // vld1/vld2 travel alongside the synchroniser. Once vld2 is set, sync2
    // holds a real key sample and not its reset value. The debouncer only
    // arms after it has seen the key released. A key that is held through
    // reset therefore cannot cause a press.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        armed_d = armed_q | (vld2_q & sync2_q);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            vld1_q      <= 1'b0;
            vld2_q      <= 1'b0;
            level_q     <= 1'b1;
            level_old_q <= 1'b1;
            armed_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= KEY_N;
            sync2_q     <= sync1_q;
            vld1_q      <= 1'b1;
            vld2_q      <= vld1_q;
            level_q     <= level_d;
            level_old_q <= level_q;
            armed_q     <= armed_d;
            cnt_q       <= cnt_d;
        end
    end

    assign PRESS = armed_q & level_old_q & ~level_q;

endmodule

// File: rtl/operand_entry.sv
// Operand capture stage for the adding machine.
// Debounced ENTER presses latch SW_IN first as A and then as B. CLEAR empties
// the pair. When CLEAR and ENTER pulse in the same cycle, CLEAR wins.
//   CLOCK_50    : system clock
//   RESET_N     : asynchronous active-low reset
//   SW_IN       : switch value, sampled at the capture edge
//   KEY_ENTER_N : raw enter key, active-low
//   KEY_CLEAR_N : raw clear key, active-low
//   A_OUT/B_OUT : held operands
//   VALID       : A and B form a completed pair
//   STATE_OUT   : FSM state, for debug LEDs
module operand_entry
    import operand_entry_pkg::*;
#(
    parameter int WIDTH           = OPERAND_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_50MHZ
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] SW_IN,
    input  logic             KEY_ENTER_N,
    input  logic             KEY_CLEAR_N,
    output logic [WIDTH-1:0] A_OUT,
    output logic [WIDTH-1:0] B_OUT,
    output logic             VALID,
    output logic [1:0]       STATE_OUT
);

    logic             enter_press, clear_press;
    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             valid_q, valid_d;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_enter (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .KEY_N    (KEY_ENTER_N),
        .PRESS    (enter_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_clear (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .KEY_N    (KEY_CLEAR_N),
        .PRESS    (clear_press)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        valid_d = valid_q;
        if (clear_press) begin
            state_d = WAIT_A;
            a_d     = '0;
            b_d     = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                WAIT_A: if (enter_press) begin
                    a_d     = SW_IN;
                    b_d     = '0;
                    state_d = WAIT_B;
                end
                WAIT_B: if (enter_press) begin
                    b_d     = SW_IN;
                    valid_d = 1'b1;
                    state_d = DONE;
                end
                // Entering from DONE starts a new pair in a single press.
                DONE: if (enter_press) begin
                    a_d     = SW_IN;
                    b_d     = '0;
                    valid_d = 1'b0;
                    state_d = WAIT_B;
                end
                default: state_d = WAIT_A;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
        end
    end

    assign A_OUT     = a_q;
    assign B_OUT     = b_q;
    assign VALID     = valid_q;
    assign STATE_OUT = state_q;

endmodule

// File: tb/tb_operand_entry.sv
module tb_operand_entry;

    localparam int W = 5;

    logic         CLOCK_50 = 1'b0;
    logic         RESET_N;
    logic [W-1:0] SW_IN;
    logic         KEY_ENTER_N;
    logic         KEY_CLEAR_N;
    logic [W-1:0] A_OUT, B_OUT;
    logic         VALID;
    logic [1:0]   STATE_OUT;

    int vec_count  = 0;
    int miss_count = 0;

    operand_entry #(.WIDTH(W), .DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET_N     (RESET_N),
        .SW_IN       (SW_IN),
        .KEY_ENTER_N (KEY_ENTER_N),
        .KEY_CLEAR_N (KEY_CLEAR_N),
        .A_OUT       (A_OUT),
        .B_OUT       (B_OUT),
        .VALID       (VALID),
        .STATE_OUT   (STATE_OUT)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Advance n rising edges and settle just after the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic do_reset();
        KEY_ENTER_N = 1'b1;
        KEY_CLEAR_N = 1'b1;
        RESET_N     = 1'b0;
        tick(2);
        RESET_N = 1'b1;
        tick(4);
    endtask

    task automatic test_reset();
        do_reset();
        vec_count++;
        if ({A_OUT, B_OUT, VALID, STATE_OUT} !== {5'd0, 5'd0, 1'b0, 2'b00}) begin
            miss_count++;
            $display("FAIL reset: A=%0d B=%0d V=%b S=%b, want 0 0 0 00", A_OUT, B_OUT, VALID, STATE_OUT);
        end
    endtask

    task automatic test_capture();
        SW_IN = 5'd13;
        KEY_ENTER_N = 1'b0;
        tick(6);
        vec_count++;
        if (A_OUT !== 5'd0 || STATE_OUT !== 2'b00) begin
            miss_count++;
            $display("FAIL capture_a_early: A=%0d S=%b at edge 6, want 0 00", A_OUT, STATE_OUT);
        end
        tick(1);
        vec_count++;
        if ({A_OUT, B_OUT, VALID, STATE_OUT} !== {5'd13, 5'd0, 1'b0, 2'b01}) begin
            miss_count++;
            $display("FAIL capture_a: A=%0d B=%0d V=%b S=%b, want 13 0 0 01", A_OUT, B_OUT, VALID, STATE_OUT);
        end
        KEY_ENTER_N = 1'b1;
        tick(8);
        SW_IN = 5'd19;
        KEY_ENTER_N = 1'b0;
        tick(6);
        vec_count++;
        if (VALID !== 1'b0 || STATE_OUT !== 2'b01) begin
            miss_count++;
            $display("FAIL capture_b_early: V=%b S=%b at edge 6, want 0 01", VALID, STATE_OUT);
        end
        tick(1);
        vec_count++;
        if ({A_OUT, B_OUT, VALID, STATE_OUT} !== {5'd13, 5'd19, 1'b1, 2'b10}) begin
            miss_count++;
            $display("FAIL capture_b: A=%0d B=%0d V=%b S=%b, want 13 19 1 10", A_OUT, B_OUT, VALID, STATE_OUT);
        end
        KEY_ENTER_N = 1'b1;
        tick(8);
    endtask

    task automatic test_done_restart();
        SW_IN = 5'd31;
        KEY_ENTER_N = 1'b0;
        tick(7);
        vec_count++;
        if ({A_OUT, B_OUT, VALID, STATE_OUT} !== {5'd31, 5'd0, 1'b0, 2'b01}) begin
            miss_count++;
            $display("FAIL done_restart: A=%0d B=%0d V=%b S=%b, want 31 0 0 01", A_OUT, B_OUT, VALID, STATE_OUT);
        end
        KEY_ENTER_N = 1'b1;
        tick(8);
    endtask

    task automatic test_clear_enter();
        SW_IN = 5'd6;
        KEY_ENTER_N = 1'b0;
        KEY_CLEAR_N = 1'b0;
        tick(7);
        vec_count++;
        if ({A_OUT, B_OUT, VALID, STATE_OUT} !== {5'd0, 5'd0, 1'b0, 2'b00}) begin
            miss_count++;
            $display("FAIL clear_wins: A=%0d B=%0d V=%b S=%b, want 0 0 0 00", A_OUT, B_OUT, VALID, STATE_OUT);
        end
        KEY_ENTER_N = 1'b1;
        KEY_CLEAR_N = 1'b1;
        tick(8);
        vec_count++;
        if (STATE_OUT !== 2'b00) begin
            miss_count++;
            $display("FAIL clear_release: S=%b, want 00", STATE_OUT);
        end
    endtask

    task automatic test_bounce();
        do_reset();
        SW_IN = 5'd7;
        for (int i = 0; i < 4; i++) begin
            KEY_ENTER_N = i[0];
            tick(2);
        end
        vec_count++;
        if (A_OUT !== 5'd0 || STATE_OUT !== 2'b00) begin
            miss_count++;
            $display("FAIL bounce_quiet: A=%0d S=%b, want 0 00", A_OUT, STATE_OUT);
        end
        KEY_ENTER_N = 1'b0;
        tick(6);
        vec_count++;
        if (STATE_OUT !== 2'b00) begin
            miss_count++;
            $display("FAIL bounce_early: S=%b at hold edge 6, want 00", STATE_OUT);
        end
        tick(4);
        vec_count++;
        if ({A_OUT, B_OUT, STATE_OUT} !== {5'd7, 5'd0, 2'b01}) begin
            miss_count++;
            $display("FAIL bounce_once: A=%0d B=%0d S=%b, want 7 0 01", A_OUT, B_OUT, STATE_OUT);
        end
        KEY_ENTER_N = 1'b1;
        tick(10);
        vec_count++;
        if ({A_OUT, B_OUT, STATE_OUT} !== {5'd7, 5'd0, 2'b01}) begin
            miss_count++;
            $display("FAIL bounce_release: A=%0d B=%0d S=%b, want 7 0 01", A_OUT, B_OUT, STATE_OUT);
        end
    endtask

    task automatic test_reset_mid();
        SW_IN = 5'd9;
        KEY_ENTER_N = 1'b0;
        tick(4);
        RESET_N = 1'b0;
        #1;
        vec_count++;
        if ({A_OUT, B_OUT, VALID, STATE_OUT} !== {5'd0, 5'd0, 1'b0, 2'b00}) begin
            miss_count++;
            $display("FAIL reset_async: A=%0d B=%0d V=%b S=%b, want 0 0 0 00", A_OUT, B_OUT, VALID, STATE_OUT);
        end
        tick(1);
        RESET_N = 1'b1;
        tick(12);
        vec_count++;
        if (A_OUT !== 5'd0 || STATE_OUT !== 2'b00) begin
            miss_count++;
            $display("FAIL reset_held_key: A=%0d S=%b, want 0 00", A_OUT, STATE_OUT);
        end
        KEY_ENTER_N = 1'b1;
        tick(8);
        vec_count++;
        if (STATE_OUT !== 2'b00) begin
            miss_count++;
            $display("FAIL reset_release: S=%b, want 00", STATE_OUT);
        end
        KEY_ENTER_N = 1'b0;
        tick(7);
        vec_count++;
        if ({A_OUT, STATE_OUT} !== {5'd9, 2'b01}) begin
            miss_count++;
            $display("FAIL reset_repress: A=%0d S=%b, want 9 01", A_OUT, STATE_OUT);
        end
        KEY_ENTER_N = 1'b1;
        tick(8);
    endtask

    task automatic test_long_hold();
        SW_IN = 5'd21;
        KEY_ENTER_N = 1'b0;
        tick(1000);
        vec_count++;
        if ({A_OUT, B_OUT, VALID, STATE_OUT} !== {5'd9, 5'd21, 1'b1, 2'b10}) begin
            miss_count++;
            $display("FAIL long_hold: A=%0d B=%0d V=%b S=%b, want 9 21 1 10", A_OUT, B_OUT, VALID, STATE_OUT);
        end
        KEY_ENTER_N = 1'b1;
        tick(20);
        vec_count++;
        if ({A_OUT, B_OUT, VALID, STATE_OUT} !== {5'd9, 5'd21, 1'b1, 2'b10}) begin
            miss_count++;
            $display("FAIL long_release: A=%0d B=%0d V=%b S=%b, want 9 21 1 10", A_OUT, B_OUT, VALID, STATE_OUT);
        end
    endtask

    initial begin
        RESET_N     = 1'b0;
        SW_IN       = '0;
        KEY_ENTER_N = 1'b1;
        KEY_CLEAR_N = 1'b1;
        test_reset();
        test_capture();
        test_done_restart();
        test_clear_enter();
        test_bounce();
        test_reset_mid();
        test_long_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
